ac_axis_lane_dispatch: RTL and testbench

//  Multi-lane input dispatcher for the access-control path: accepts the source-image AXI4-Stream
//  and distributes pixels to N_PARALLEL upsampler lanes, each through its own small FIFO.

---
 rtl/ac_axis_lane_dispatch_pkg.sv | 16 +
 rtl/ac_axis_lane_dispatch_if.sv | 25 ++
 rtl/ac_axis_lane_dispatch_lane_fifo.sv | 46 ++++
 rtl/ac_axis_lane_dispatch.sv | 178 +++++++++++++++++
 tb/tb_ac_axis_lane_dispatch.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_axis_lane_dispatch_pkg.sv
// Shared types and helpers for the access-control lane dispatcher.
package ac_axis_lane_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ac_state_e;

    // Index width that never collapses to zero bits for counts of 1 or 2.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ac_axis_lane_dispatch_if.sv
// Source-image stream plus the per-lane outputs towards the upsamplers.
interface ac_axis_lane_dispatch_if #(
    parameter int DW = 24,
    parameter int N  = 4
);
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tlast;
    logic            s_axis_tuser;
    logic [N-1:0]    lane_valid;
    logic [N-1:0]    lane_ready;
    logic [N*DW-1:0] lane_data;
    logic [N-1:0]    lane_last;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, lane_ready,
        output s_axis_tready, lane_valid, lane_data, lane_last
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser, lane_ready,
        input  s_axis_tready, lane_valid, lane_data, lane_last
    );
endinterface

// File: rtl/ac_axis_lane_dispatch_lane_fifo.sv
// First-word fall-through lane FIFO; pointers carry an extra wrap bit for full/empty.
module ac_axis_lane_dispatch_lane_fifo
    import ac_axis_lane_dispatch_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/ac_axis_lane_dispatch.sv
// Splits the source-image stream across N_PARALLEL lane FIFOs, one frame per crf_ac_UPSTART.
// state | meaning: IDLE wait start | RUN accept pixels | DRAIN wait lanes empty | DONE done pulse
module ac_axis_lane_dispatch
    import ac_axis_lane_dispatch_pkg::*;
#(
    parameter int AXISIN_DATA_WIDTH = 24,
    parameter int N_PARALLEL        = 4,
    parameter int LANE_DEPTH        = 4,
    parameter int SRC_IMG_WIDTH     = 960,
    parameter int SRC_IMG_HEIGHT    = 540,
    parameter int CRF_DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      crf_ac_UPSTART,
    input  logic                      crf_ac_mode,
    ac_axis_lane_dispatch_if.slave    bus,
    output logic                      ac_crf_processing,
    output logic                      ac_crf_done,
    output logic [CRF_DATA_WIDTH-1:0] ac_crf_hskcnt,
    output logic                      ac_crf_err_last,
    output logic                      ac_crf_err_user
);
    localparam int DW  = AXISIN_DATA_WIDTH;
    localparam int N   = N_PARALLEL;
    localparam int BLK = SRC_IMG_WIDTH / N_PARALLEL;
    localparam int LW  = clog2_min1(N);
    localparam int CW  = clog2_min1(SRC_IMG_WIDTH);
    localparam int RW  = clog2_min1(SRC_IMG_HEIGHT);
    localparam int BW  = clog2_min1(BLK);

    localparam logic [CW-1:0] COL_LAST  = CW'(SRC_IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TAIL  = CW'(SRC_IMG_WIDTH - N);
    localparam logic [RW-1:0] ROW_LAST  = RW'(SRC_IMG_HEIGHT - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(N - 1);
    localparam logic [BW-1:0] BCOL_LAST = BW'(BLK - 1);

    ac_state_e               state_q, state_d;
    logic                    mode_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [LW-1:0]           lane_q;
    logic [LW-1:0]           blk_q;
    logic [BW-1:0]           bcol_q;
    logic [CRF_DATA_WIDTH-1:0] hskcnt_q;
    logic                    err_last_q;
    logic                    err_user_q;

    logic                    run;
    logic                    tready;
    logic                    accept;
    logic                    start;
    logic                    frame_end;
    logic                    all_empty;
    logic [LW-1:0]           tgt;
    logic                    lastflag;
    logic                    tgt_full;
    logic [N-1:0]            fifo_full;
    logic [N-1:0]            fifo_empty;
    logic [DW:0]             rd_word [N];

    always_comb begin
        tgt      = mode_q ? blk_q : lane_q;
        lastflag = mode_q ? (bcol_q == BCOL_LAST) : (col_q >= COL_TAIL);
        tgt_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (LW'(i) == tgt) tgt_full = fifo_full[i];
        end
    end

    assign tready    = run & ~tgt_full;
    assign accept    = bus.s_axis_tvalid & tready;
    assign start     = (state_q == ST_IDLE) & crf_ac_UPSTART;
    assign frame_end = accept & (row_q == ROW_LAST) & (col_q == COL_LAST);
    assign all_empty = &fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (crf_ac_UPSTART) state_d = ST_RUN;
            ST_RUN:   if (frame_end)      state_d = ST_DRAIN;
            ST_DRAIN: if (all_empty)      state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run               = 1'b0;
        ac_crf_processing = 1'b0;
        ac_crf_done       = 1'b0;
        case (state_q)
            ST_RUN:   begin run = 1'b1; ac_crf_processing = 1'b1; end
            ST_DRAIN: ac_crf_processing = 1'b1;
            ST_DONE:  ac_crf_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            lane_q     <= '0;
            blk_q      <= '0;
            bcol_q     <= '0;
            hskcnt_q   <= '0;
            err_last_q <= 1'b0;
            err_user_q <= 1'b0;
        end else if (start) begin
            mode_q     <= crf_ac_mode;
            col_q      <= '0;
            row_q      <= '0;
            lane_q     <= '0;
            blk_q      <= '0;
            bcol_q     <= '0;
            hskcnt_q   <= '0;
            err_last_q <= 1'b0;
            err_user_q <= 1'b0;
        end else if (accept) begin
            if (hskcnt_q != '1) hskcnt_q <= hskcnt_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            lane_q <= (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
            if (bcol_q == BCOL_LAST) begin
                bcol_q <= '0;
                blk_q  <= (blk_q == LANE_LAST) ? '0 : blk_q + 1'b1;
            end else begin
                bcol_q <= bcol_q + 1'b1;
            end
            // Framing is only flagged; the frame always ends on the pixel count.
            err_last_q <= err_last_q | (bus.s_axis_tlast != (col_q == COL_LAST));
            err_user_q <= err_user_q | (bus.s_axis_tuser != ((col_q == '0) && (row_q == '0)));
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        ac_axis_lane_dispatch_lane_fifo #(
            .WIDTH (DW + 1),
            .DEPTH (LANE_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (accept && (tgt == LW'(g))),
            .push_data_i ({bus.s_axis_tdata, lastflag}),
            .pop_i       (bus.lane_ready[g]),
            .rd_data_o   (rd_word[g]),
            .empty_o     (fifo_empty[g]),
            .full_o      (fifo_full[g])
        );
    end

    always_comb begin
        bus.lane_data = '0;
        bus.lane_last = '0;
        for (int i = 0; i < N; i++) begin
            bus.lane_data[i*DW +: DW] = rd_word[i][DW:1];
            bus.lane_last[i]          = rd_word[i][0];
        end
    end

    assign bus.lane_valid    = ~fifo_empty;
    assign bus.s_axis_tready = tready;
    assign ac_crf_hskcnt     = hskcnt_q;
    assign ac_crf_err_last   = err_last_q;
    assign ac_crf_err_user   = err_user_q;

endmodule

// File: tb/tb_ac_axis_lane_dispatch.sv
// Directed bench: an 8x2 instance for split modes/framing/drain/reset and a 16x2 instance for lane stall.
module tb_ac_axis_lane_dispatch;
    typedef struct packed {
        logic [1:0]  lane;
        logic [24:0] val;
    } pop_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        upstart;
    logic        mode;
    logic        tvalid;
    logic [23:0] tdata;
    logic        tlast;
    logic        tuser;
    logic [3:0]  lane_ready;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_pop_cyc = 0;
    int          first_stall = -1;
    pop_t        pops[$];

    ac_axis_lane_dispatch_if #(.DW(24), .N(4)) if8 ();
    ac_axis_lane_dispatch_if #(.DW(24), .N(4)) if16 ();

    logic        p8, d8, el8, eu8, p16, d16, el16, eu16;
    logic [31:0] h8, h16;

    assign if8.s_axis_tvalid  = tvalid & ~sel;
    assign if8.s_axis_tdata   = tdata;
    assign if8.s_axis_tlast   = tlast;
    assign if8.s_axis_tuser   = tuser;
    assign if8.lane_ready     = lane_ready;
    assign if16.s_axis_tvalid = tvalid & sel;
    assign if16.s_axis_tdata  = tdata;
    assign if16.s_axis_tlast  = tlast;
    assign if16.s_axis_tuser  = tuser;
    assign if16.lane_ready    = lane_ready;

    ac_axis_lane_dispatch #(
        .AXISIN_DATA_WIDTH(24), .N_PARALLEL(4), .LANE_DEPTH(4),
        .SRC_IMG_WIDTH(8), .SRC_IMG_HEIGHT(2), .CRF_DATA_WIDTH(32)
    ) dut8 (
        .clk(clk), .rst(rst), .crf_ac_UPSTART(upstart & ~sel), .crf_ac_mode(mode),
        .bus(if8), .ac_crf_processing(p8), .ac_crf_done(d8), .ac_crf_hskcnt(h8),
        .ac_crf_err_last(el8), .ac_crf_err_user(eu8)
    );

    ac_axis_lane_dispatch #(
        .AXISIN_DATA_WIDTH(24), .N_PARALLEL(4), .LANE_DEPTH(4),
        .SRC_IMG_WIDTH(16), .SRC_IMG_HEIGHT(2), .CRF_DATA_WIDTH(32)
    ) dut16 (
        .clk(clk), .rst(rst), .crf_ac_UPSTART(upstart & sel), .crf_ac_mode(mode),
        .bus(if16), .ac_crf_processing(p16), .ac_crf_done(d16), .ac_crf_hskcnt(h16),
        .ac_crf_err_last(el16), .ac_crf_err_user(eu16)
    );

    logic        o_tready, o_proc, o_done, o_errl, o_erru;
    logic [3:0]  o_lane_valid, o_lane_last;
    logic [95:0] o_lane_data;
    logic [31:0] o_hsk;

    assign o_tready     = sel ? if16.s_axis_tready : if8.s_axis_tready;
    assign o_lane_valid = sel ? if16.lane_valid : if8.lane_valid;
    assign o_lane_last  = sel ? if16.lane_last : if8.lane_last;
    assign o_lane_data  = sel ? if16.lane_data : if8.lane_data;
    assign o_proc       = sel ? p16 : p8;
    assign o_done       = sel ? d16 : d8;
    assign o_hsk        = sel ? h16 : h8;
    assign o_errl       = sel ? el16 : el8;
    assign o_erru       = sel ? eu16 : eu8;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        for (int i = 0; i < 4; i++) begin
            if (o_lane_valid[i] && lane_ready[i]) begin
                pops.push_back({2'(i), o_lane_data[i*24 +: 24], o_lane_last[i]});
                last_pop_cyc <= cyc;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        upstart = 1'b1;
        @(negedge clk);
        upstart = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge with tvalid low.
    task automatic send_beats(input int w, input int first, input int count, input bit bad);
        for (int k = first; k < first + count; k++) begin
            int r, c, guard;
            r = k / w;
            c = k % w;
            tvalid = 1'b1;
            tdata  = {8'hA5, 8'(r), 8'(c)};
            tlast  = bad ? ((c == w - 1) || (c == 3)) : (c == w - 1);
            tuser  = bad ? 1'b0 : (k == 0);
            guard  = 0;
            while (!o_tready && guard < 2000) begin
                if (first_stall < 0) first_stall = k;
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) begin
                n_checks++;
                $display("FAIL send_timeout: beat %0d never accepted, tready=%0b want 1", k, o_tready);
                tvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int g;
        g = 0;
        while (done_cnt == d0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (done_cnt == d0) $display("FAIL %s_done_timeout: done count %0d want %0d", nm, done_cnt, d0 + 1);
        else n_pass++;
    endtask

    task automatic check_lanes(input string nm, input int w, input int h, input bit m);
        for (int ln = 0; ln < 4; ln++) begin
            logic [24:0] got[$];
            logic [24:0] exp_q[$];
            int blk, bad_at;
            blk    = w / 4;
            bad_at = -1;
            foreach (pops[j]) if (int'(pops[j].lane) == ln) got.push_back(pops[j].val);
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    if ((m ? c / blk : c % 4) == ln)
                        exp_q.push_back({8'hA5, 8'(r), 8'(c),
                                         1'(m ? (c % blk == blk - 1) : (c >= w - 4))});
            foreach (exp_q[j]) begin
                if (bad_at < 0 && (j >= got.size() || got[j] !== exp_q[j])) bad_at = j;
            end
            if (bad_at < 0 && got.size() != exp_q.size()) bad_at = exp_q.size();
            n_checks++;
            if (bad_at >= 0)
                $display("FAIL %s_lane%0d: got %0d words, differs at entry %0d, want %0d words",
                         nm, ln, got.size(), bad_at, exp_q.size());
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (o_tready !== 1'b0) $display("FAIL rst_tready: got %b want 0", o_tready); else n_pass++;
        n_checks++; if (o_lane_valid !== 4'h0) $display("FAIL rst_lane_valid: got %h want 0", o_lane_valid); else n_pass++;
        n_checks++; if (o_lane_data !== 96'h0) $display("FAIL rst_lane_data: got %h want 0", o_lane_data); else n_pass++;
        n_checks++; if (o_proc !== 1'b0 || o_done !== 1'b0) $display("FAIL rst_proc_done: got %b%b want 00", o_proc, o_done); else n_pass++;
        n_checks++; if (o_hsk !== 32'd0) $display("FAIL rst_hskcnt: got %0d want 0", o_hsk); else n_pass++;
        n_checks++; if (o_errl !== 1'b0 || o_erru !== 1'b0) $display("FAIL rst_errs: got %b%b want 00", o_errl, o_erru); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame(input string nm, input bit m);
        int d0;
        sel = 1'b0; mode = m; lane_ready = 4'hF; pops.delete();
        d0 = done_cnt;
        pulse_start();
        send_beats(8, 0, 16, 1'b0);
        wait_done(nm, d0);
        repeat (3) @(negedge clk);
        check_lanes(nm, 8, 2, m);
        n_checks++; if (o_hsk !== 32'd16) $display("FAIL %s_hskcnt: got %0d want 16", nm, o_hsk); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL %s_done_pulses: got %0d want 1", nm, done_cnt - d0); else n_pass++;
        n_checks++; if (o_proc !== 1'b0) $display("FAIL %s_proc_after: got %b want 0", nm, o_proc); else n_pass++;
        n_checks++; if (o_errl !== 1'b0 || o_erru !== 1'b0) $display("FAIL %s_errs: got %b%b want 00", nm, o_errl, o_erru); else n_pass++;
    endtask

    task automatic test_mode_interleaved();
        run_frame("mode0", 1'b0);
    endtask

    task automatic test_mode_block();
        run_frame("mode1", 1'b1);
    endtask

    // Lane 2 of a 16-wide row gets cols 2,6,10,14; those fill its 4 entries, so row 1 col 2 (beat 18) stalls.
    task automatic test_stall();
        int d0;
        sel = 1'b1; mode = 1'b0; lane_ready = 4'b1011; pops.delete();
        first_stall = -1;
        d0 = done_cnt;
        pulse_start();
        fork
            send_beats(16, 0, 32, 1'b0);
            begin
                int g;
                g = 0;
                while (first_stall < 0 && g < 300) begin
                    @(negedge clk);
                    g++;
                end
                n_checks++; if (first_stall != 18) $display("FAIL stall_beat: got %0d want 18", first_stall); else n_pass++;
                repeat (8) @(negedge clk);
                n_checks++; if (o_tready !== 1'b0) $display("FAIL stall_tready_held: got %b want 0", o_tready); else n_pass++;
                n_checks++; if (o_hsk !== 32'd18) $display("FAIL stall_hskcnt: got %0d want 18", o_hsk); else n_pass++;
                n_checks++; if (o_lane_valid[2] !== 1'b1) $display("FAIL stall_lane2_valid: got %b want 1", o_lane_valid[2]); else n_pass++;
                lane_ready[2] = 1'b1;
            end
        join
        wait_done("stall", d0);
        repeat (2) @(negedge clk);
        check_lanes("stall", 16, 2, 1'b0);
        n_checks++; if (o_hsk !== 32'd32) $display("FAIL stall_hskcnt_end: got %0d want 32", o_hsk); else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_framing();
        int d0;
        sel = 1'b0; mode = 1'b0; lane_ready = 4'hF; pops.delete();
        d0 = done_cnt;
        pulse_start();
        send_beats(8, 0, 16, 1'b1);
        wait_done("framing", d0);
        repeat (2) @(negedge clk);
        n_checks++; if (o_errl !== 1'b1) $display("FAIL framing_err_last: got %b want 1", o_errl); else n_pass++;
        n_checks++; if (o_erru !== 1'b1) $display("FAIL framing_err_user: got %b want 1", o_erru); else n_pass++;
        n_checks++; if (o_hsk !== 32'd16) $display("FAIL framing_hskcnt: got %0d want 16", o_hsk); else n_pass++;
        d0 = done_cnt;
        pulse_start();
        n_checks++; if (o_errl !== 1'b0 || o_erru !== 1'b0) $display("FAIL framing_clear: got %b%b want 00", o_errl, o_erru); else n_pass++;
        send_beats(8, 0, 16, 1'b0);
        wait_done("framing2", d0);
        n_checks++; if (o_errl !== 1'b0 || o_erru !== 1'b0) $display("FAIL framing_clean_frame: got %b%b want 00", o_errl, o_erru); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b0; mode = 1'b1; lane_ready = 4'h0;
        pulse_start();
        send_beats(8, 0, 6, 1'b0);
        n_checks++; if (o_lane_valid === 4'h0) $display("FAIL midrst_prefill: got %h want nonzero", o_lane_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_lane_valid !== 4'h0) $display("FAIL midrst_lane_valid: got %h want 0", o_lane_valid); else n_pass++;
        n_checks++; if (o_tready !== 1'b0) $display("FAIL midrst_tready: got %b want 0", o_tready); else n_pass++;
        n_checks++; if (o_proc !== 1'b0 || o_hsk !== 32'd0) $display("FAIL midrst_state: got proc=%b hsk=%0d want 0/0", o_proc, o_hsk); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", 1'b1);
    endtask

    task automatic test_drain_upstart_ignored();
        int d0;
        sel = 1'b0; mode = 1'b0; lane_ready = 4'h0; pops.delete();
        d0 = done_cnt;
        pulse_start();
        send_beats(8, 0, 8, 1'b0);
        pulse_start();
        send_beats(8, 8, 8, 1'b0);
        repeat (20) @(negedge clk);
        n_checks++; if (o_proc !== 1'b1) $display("FAIL drain_proc_held: got %b want 1", o_proc); else n_pass++;
        n_checks++; if (done_cnt != d0) $display("FAIL drain_no_done: got %0d pulses want 0", done_cnt - d0); else n_pass++;
        n_checks++; if (o_tready !== 1'b0) $display("FAIL drain_tready: got %b want 0", o_tready); else n_pass++;
        n_checks++; if (o_hsk !== 32'd16) $display("FAIL drain_hskcnt: got %0d want 16", o_hsk); else n_pass++;
        n_checks++; if (o_lane_valid !== 4'hF) $display("FAIL drain_lane_valid: got %h want f", o_lane_valid); else n_pass++;
        lane_ready = 4'hF;
        wait_done("drain", d0);
        // Last pop at edge P, DONE registered at P+1, seen by the edge monitor at P+2.
        n_checks++; if (done_cyc - last_pop_cyc != 2) $display("FAIL drain_done_latency: got %0d want 2", done_cyc - last_pop_cyc); else n_pass++;
        repeat (2) @(negedge clk);
        check_lanes("drain", 8, 2, 1'b0);
        n_checks++; if (o_proc !== 1'b0) $display("FAIL drain_proc_after: got %b want 0", o_proc); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; upstart = 1'b0; mode = 1'b0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = 1'b0; lane_ready = 4'h0;
        test_reset();
        test_mode_interleaved();
        test_mode_block();
        test_stall();
        test_framing();
        test_reset_mid_run();
        test_drain_upstart_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
